// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter
//   Shares one load/store unit between two requesters. Port A is the pipeline
//   MEM stage and has priority. Port B is a debug/DMA master. A starvation
//   counter forces Port B to win once it has been denied MAX_WAIT cycles in a
//   row. At most one access per cycle is forwarded to the LSU. Load results
//   come back through a fixed-latency tag pipeline, so each result goes only
//   to the port that issued the load.
//
// Parameters
//   RD_LAT   : cycles from a load grant to valid i_ld_data (0..4, 0 = same cycle)
//   MAX_WAIT : consecutive denied cycles before Port B is forced to win (1..255)
//   CNT_W    : starvation counter width, 2**CNT_W > MAX_WAIT
//
// Ports
//   i_clk, i_reset          : clock, asynchronous active-low reset
//   i_a_* / o_a_*           : Port A request fields, grant, load response
//   i_b_* / o_b_*           : Port B request fields, grant, load response
//   o_lsu_*                 : access forwarded to the LSU in the grant cycle
//   i_ld_data               : load data returned by the LSU
//
// Optional feature (macro LSU_ARB_PERF_EN)
//   Adds 32-bit wrapping counters o_perf_a_grants, o_perf_b_grants,
//   o_perf_conflicts and o_perf_forced. Arbitration is the same whether or
//   not the macro is defined.
module lsu_port_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_a_req,
  input  logic [31:0] i_a_addr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_a_wren,
  input  logic [2:0]  i_a_type,
  output logic        o_a_gnt,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic [31:0] i_b_addr,
  input  logic [31:0] i_b_wdata,
  input  logic        i_b_wren,
  input  logic [2:0]  i_b_type,
  output logic        o_b_gnt,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  output logic        o_lsu_wren,
  output logic [2:0]  o_lsu_type,
  input  logic [31:0] i_ld_data
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [31:0] o_perf_a_grants,
  output logic [31:0] o_perf_b_grants,
  output logic [31:0] o_perf_conflicts,
  output logic [31:0] o_perf_forced
`endif
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [2:0]       IDLE_TYPE  = 3'b010;

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             starve;
  logic             a_win, b_win;
  logic             ld_issue;
  logic             ret_vld, ret_port;   // ret_port: 0 = Port A, 1 = Port B

  // Arbitration: A has priority, B wins when the starvation flag is set.
  // Grants are forced low while reset is asserted.
  always_comb begin
    a_win  = 1'b0;
    b_win  = 1'b0;
    starve = (wait_q == MAX_WAIT_C);
    if (!i_reset) begin
      a_win = 1'b0;
      b_win = 1'b0;
    end else if (i_a_req && i_b_req) begin
      if (starve) begin
        b_win = 1'b1;
      end else begin
        a_win = 1'b1;
      end
    end else if (i_a_req) begin
      a_win = 1'b1;
    end else if (i_b_req) begin
      b_win = 1'b1;
    end else begin
      a_win = 1'b0;
      b_win = 1'b0;
    end
  end

  assign o_a_gnt  = a_win;
  assign o_b_gnt  = b_win;
  assign ld_issue = (a_win && !i_a_wren) || (b_win && !i_b_wren);

  // LSU request mux. With no grant the bus is parked, and write enable is low.
  always_comb begin
    o_lsu_addr  = 32'h0000_0000;
    o_lsu_wdata = 32'h0000_0000;
    o_lsu_wren  = 1'b0;
    o_lsu_type  = IDLE_TYPE;
    case ({a_win, b_win})
      2'b10: begin
        o_lsu_addr  = i_a_addr;
        o_lsu_wdata = i_a_wdata;
        o_lsu_wren  = i_a_wren;
        o_lsu_type  = i_a_type;
      end
      2'b01: begin
        o_lsu_addr  = i_b_addr;
        o_lsu_wdata = i_b_wdata;
        o_lsu_wren  = i_b_wren;
        o_lsu_type  = i_b_type;
      end
      default: begin
        o_lsu_addr  = 32'h0000_0000;
        o_lsu_wdata = 32'h0000_0000;
        o_lsu_wren  = 1'b0;
        o_lsu_type  = IDLE_TYPE;
      end
    endcase
  end

  // Starvation counter: counts denied B cycles and saturates at MAX_WAIT.
  // It clears when B is granted or withdraws its request.
  always_comb begin
    wait_d = wait_q;
    if (!i_b_req || b_win) begin
      wait_d = '0;
    end else if (starve) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Response tag pipeline. Each stage holds {valid, port}.
  // RD_LAT = 0 returns the data in the grant cycle and has no registers.
  generate
    if (RD_LAT == 0) begin : g_lat0
      assign ret_vld  = ld_issue;
      assign ret_port = b_win;
    end else begin : g_pipe
      logic [RD_LAT-1:0] vld_q, vld_d;
      logic [RD_LAT-1:0] port_q, port_d;

      // Shift the tags one stage per cycle. Stage 0 takes this cycle's load.
      always_comb begin
        vld_d     = vld_q;
        port_d    = port_q;
        vld_d[0]  = ld_issue;
        port_d[0] = b_win;
        for (int i = 1; i < RD_LAT; i++) begin
          vld_d[i]  = vld_q[i-1];
          port_d[i] = port_q[i-1];
        end
      end

      // Tag registers. Reset drops every load that is in flight.
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          vld_q  <= '0;
          port_q <= '0;
        end else begin
          vld_q  <= vld_d;
          port_q <= port_d;
        end
      end

      assign ret_vld  = vld_q[RD_LAT-1] && i_reset;
      assign ret_port = port_q[RD_LAT-1];
    end
  endgenerate

  // Route the returning load data to its owner. The other port reads zero.
  always_comb begin
    o_a_rvalid = 1'b0;
    o_b_rvalid = 1'b0;
    o_a_rdata  = 32'h0000_0000;
    o_b_rdata  = 32'h0000_0000;
    if (ret_vld && !ret_port) begin
      o_a_rvalid = 1'b1;
      o_a_rdata  = i_ld_data;
    end else if (ret_vld && ret_port) begin
      o_b_rvalid = 1'b1;
      o_b_rdata  = i_ld_data;
    end else begin
      o_a_rvalid = 1'b0;
      o_b_rvalid = 1'b0;
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [31:0] perf_a_q, perf_b_q, perf_conf_q, perf_forced_q;
  logic        conflict, forced;

  assign conflict = i_reset && i_a_req && i_b_req;
  assign forced   = conflict && starve;

  // Wrapping performance counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      perf_a_q      <= 32'h0000_0000;
      perf_b_q      <= 32'h0000_0000;
      perf_conf_q   <= 32'h0000_0000;
      perf_forced_q <= 32'h0000_0000;
    end else begin
      perf_a_q      <= perf_a_q + {31'd0, a_win};
      perf_b_q      <= perf_b_q + {31'd0, b_win};
      perf_conf_q   <= perf_conf_q + {31'd0, conflict};
      perf_forced_q <= perf_forced_q + {31'd0, forced};
    end
  end

  assign o_perf_a_grants  = perf_a_q;
  assign o_perf_b_grants  = perf_b_q;
  assign o_perf_conflicts = perf_conf_q;
  assign o_perf_forced    = perf_forced_q;
`endif

endmodule
